// File: rtl/ov5640_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_ctrl_pkg
// Shared definitions for the OV5640 capture sequencer:
//   - state_e   : 3-bit state encoding, also exported on the debug port
//   - cnt_width : width of the shared down-counter for a parameter set
//   - skip_width: width of the frame-skip counter
// ---------------------------------------------------------------------------
package ov5640_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_WAIT = 3'd1,
    INIT     = 3'd2,
    SKIP     = 3'd3,
    RUN      = 3'd4,
    RESTART  = 3'd5,
    FAULT    = 3'd6
  } state_e;

  // The counter must hold the largest load value, hence clog2(max + 1).
  // A floor of 2 bits keeps the decrement arithmetic well-formed.
  function automatic int unsigned cnt_width(
    input int unsigned pwr_dly,
    input int unsigned init_to,
    input int unsigned frame_to,
    input int unsigned rst_hold
  );
    int unsigned max_v;
    int unsigned w;
    max_v = pwr_dly;
    max_v = (init_to  > max_v) ? init_to  : max_v;
    max_v = (frame_to > max_v) ? frame_to : max_v;
    max_v = (rst_hold > max_v) ? rst_hold : max_v;
    w     = $clog2(max_v + 32'd1);
    return (w < 32'd2) ? 32'd2 : w;
  endfunction

  // Skip counter counts 0..n-1; at least one bit even when skipping is off.
  function automatic int unsigned skip_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser followed by a registered rising-edge detector.
// A raw input edge produces a one-cycle `rise` pulse 3 clk cycles later.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every flop
//   din   : asynchronous input
//   rise  : registered one-cycle pulse on each synchronised rising edge
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic rise_r;

  // Synchroniser chain, delayed copy and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/ov5640_cap_seq.sv
// ---------------------------------------------------------------------------
// ov5640_cap_seq
// Bring-up and supervision sequencer for the OV5640 camera driver.
// Power-on delay, SCCB init wait, auto-exposure frame skipping, vsync
// watchdog with bounded restarts and a latched fault.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   enable         : level, 1 runs the sequence, 0 returns to IDLE
//   cam_init_done  : register-config engine finished (clk domain)
//   cam_vsync      : raw vsync from the pclk domain
//   capture_start  : driver run / reset release
//   frame_en       : downstream may accept frame data
//   frame_cnt      : frames seen in RUN (wrapping)
//   retry_cnt      : restarts since enable rose
//   busy, fault    : status flags
//   state          : current state encoding (debug)
// ---------------------------------------------------------------------------
module ov5640_cap_seq
  import ov5640_ctrl_pkg::*;
#(
  parameter int unsigned PWR_DLY_CYC  = 1_000_000,
  parameter int unsigned INIT_TO_CYC  = 25_000_000,
  parameter int unsigned SKIP_FRAMES  = 10,
  parameter int unsigned FRAME_TO_CYC = 5_000_000,
  parameter int unsigned RST_HOLD_CYC = 16,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cam_init_done,
  input  logic        cam_vsync,
  output logic        capture_start,
  output logic        frame_en,
  output logic [15:0] frame_cnt,
  output logic [2:0]  retry_cnt,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W  = cnt_width(PWR_DLY_CYC, INIT_TO_CYC, FRAME_TO_CYC, RST_HOLD_CYC);
  localparam int unsigned SKIP_W = skip_width(SKIP_FRAMES);

  // A state holds for (load + 1) cycles, so RESTART loads one less to keep
  // capture_start low for exactly RST_HOLD_CYC cycles.
  localparam logic [CNT_W-1:0]  LD_PWR   = CNT_W'(PWR_DLY_CYC);
  localparam logic [CNT_W-1:0]  LD_INIT  = CNT_W'(INIT_TO_CYC);
  localparam logic [CNT_W-1:0]  LD_FRAME = CNT_W'(FRAME_TO_CYC);
  localparam logic [CNT_W-1:0]  LD_HOLD  = CNT_W'(RST_HOLD_CYC - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 32'd1);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1'b1);
  localparam logic [2:0]        RETRY_LIM = 3'(MAX_RETRY);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [SKIP_W-1:0]  skip_cnt_r;
  logic [15:0]        frame_cnt_r;
  logic [2:0]         retry_cnt_r;
  logic               capture_start_r;
  logic               frame_en_r;
  logic               busy_r;
  logic               fault_r;
  logic               vs_rise_s;

  sync_edge_det u_vs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cam_vsync),
    .rise  (vs_rise_s)
  );

  // Sequencer FSM with shared down-counter, skip counter and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      skip_cnt_r      <= '0;
      frame_cnt_r     <= 16'd0;
      retry_cnt_r     <= 3'd0;
      capture_start_r <= 1'b0;
      frame_en_r      <= 1'b0;
      busy_r          <= 1'b0;
      fault_r         <= 1'b0;
    end else if (!enable) begin
      // Statistics are kept for inspection until the next bring-up.
      state_r         <= IDLE;
      cnt_r           <= '0;
      capture_start_r <= 1'b0;
      frame_en_r      <= 1'b0;
      busy_r          <= 1'b0;
      fault_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= PWR_WAIT;
          cnt_r       <= LD_PWR;
          frame_cnt_r <= 16'd0;
          retry_cnt_r <= 3'd0;
          busy_r      <= 1'b1;
          fault_r     <= 1'b0;
        end

        PWR_WAIT: begin
          if (cnt_r == '0) begin
            state_r         <= INIT;
            cnt_r           <= LD_INIT;
            capture_start_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        INIT: begin
          // Done is checked first so it wins over a simultaneous timeout.
          if (cam_init_done) begin
            cnt_r <= LD_FRAME;
            if (SKIP_FRAMES == 32'd0) begin
              state_r    <= RUN;
              frame_en_r <= 1'b1;
              busy_r     <= 1'b0;
            end else begin
              state_r    <= SKIP;
              skip_cnt_r <= '0;
            end
          end else if (cnt_r == '0) begin
            state_r         <= RESTART;
            cnt_r           <= LD_HOLD;
            capture_start_r <= 1'b0;
            frame_en_r      <= 1'b0;
            retry_cnt_r     <= retry_cnt_r + 3'd1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        SKIP: begin
          // An edge always reloads the watchdog, even on its expiry cycle.
          if (vs_rise_s) begin
            cnt_r <= LD_FRAME;
            if (skip_cnt_r == SKIP_LAST) begin
              state_r    <= RUN;
              frame_en_r <= 1'b1;
              busy_r     <= 1'b0;
            end else begin
              skip_cnt_r <= skip_cnt_r + SKIP_ONE;
            end
          end else if (cnt_r == '0) begin
            state_r         <= RESTART;
            cnt_r           <= LD_HOLD;
            capture_start_r <= 1'b0;
            frame_en_r      <= 1'b0;
            retry_cnt_r     <= retry_cnt_r + 3'd1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        RUN: begin
          if (vs_rise_s) begin
            cnt_r       <= LD_FRAME;
            frame_cnt_r <= frame_cnt_r + 16'd1;
          end else if (cnt_r == '0) begin
            state_r         <= RESTART;
            cnt_r           <= LD_HOLD;
            capture_start_r <= 1'b0;
            frame_en_r      <= 1'b0;
            busy_r          <= 1'b1;
            retry_cnt_r     <= retry_cnt_r + 3'd1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        RESTART: begin
          if (cnt_r == '0) begin
            if (retry_cnt_r == RETRY_LIM) begin
              state_r <= FAULT;
              busy_r  <= 1'b0;
              fault_r <= 1'b1;
            end else begin
              state_r         <= INIT;
              cnt_r           <= LD_INIT;
              capture_start_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        FAULT: begin
          // Latched until enable drops.
          state_r         <= FAULT;
          cnt_r           <= cnt_r;
          capture_start_r <= 1'b0;
          frame_en_r      <= 1'b0;
          fault_r         <= 1'b1;
        end

        default: begin
          state_r         <= IDLE;
          cnt_r           <= '0;
          capture_start_r <= 1'b0;
          frame_en_r      <= 1'b0;
          busy_r          <= 1'b0;
          fault_r         <= 1'b0;
        end
      endcase
    end
  end

  assign capture_start = capture_start_r;
  assign frame_en      = frame_en_r;
  assign frame_cnt     = frame_cnt_r;
  assign retry_cnt     = retry_cnt_r;
  assign busy          = busy_r;
  assign fault         = fault_r;
  assign state         = state_r;

endmodule

// File: tb/tb_ov5640_cap_seq.sv
// ---------------------------------------------------------------------------
// tb_ov5640_cap_seq
// Scoreboard bench: the stimulus thread pushes the expected state transition
// records (cycle, state, all outputs) into a queue; a monitor pops and
// compares one record each time the DUT state changes. Raw vsync edges are
// scheduled through a queue of cycle numbers.
// ---------------------------------------------------------------------------
module tb_ov5640_cap_seq;
  import ov5640_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cam_init_done;
  logic        cam_vsync;
  logic        capture_start;
  logic        frame_en;
  logic [15:0] frame_cnt;
  logic [2:0]  retry_cnt;
  logic        busy;
  logic        fault;
  logic [2:0]  state;

  ov5640_cap_seq #(
    .PWR_DLY_CYC  (100),
    .INIT_TO_CYC  (500),
    .SKIP_FRAMES  (2),
    .FRAME_TO_CYC (300),
    .RST_HOLD_CYC (16),
    .MAX_RETRY    (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cam_init_done (cam_init_done),
    .cam_vsync     (cam_vsync),
    .capture_start (capture_start),
    .frame_en      (frame_en),
    .frame_cnt     (frame_cnt),
    .retry_cnt     (retry_cnt),
    .busy          (busy),
    .fault         (fault),
    .state         (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          at;
    logic [2:0]  st;
    logic        cs;
    logic        fe;
    logic        bz;
    logic        ft;
    logic [2:0]  rt;
    logic [15:0] fc;
  } ev_t;

  ev_t exp_q[$];
  int  vs_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic expect_ev(input string name, input int at, input logic [2:0] st,
                           input logic cs, input logic fe, input logic bz, input logic ft,
                           input logic [2:0] rt, input logic [15:0] fc);
    ev_t e;
    e.name = name; e.at = at; e.st = st; e.cs = cs; e.fe = fe;
    e.bz = bz; e.ft = ft; e.rt = rt; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({capture_start, frame_en, frame_cnt, retry_cnt, busy, fault, state} !== 26'd0) begin
      fails++;
      $display("FAIL %s: got cs=%0b fe=%0b fcnt=%0d retry=%0d busy=%0b fault=%0b state=%0d, required all 0",
               name, capture_start, frame_en, frame_cnt, retry_cnt, busy, fault, state);
    end
  endtask

  // vsync generator: raise at each scheduled cycle, hold high 20 cycles
  initial begin
    int vs_fall;
    vs_fall = 0;
    cam_vsync = 1'b0;
    forever begin
      @(negedge clk);
      if (vs_q.size() > 0 && cyc == vs_q[0]) begin
        void'(vs_q.pop_front());
        cam_vsync = 1'b1;
        vs_fall = cyc + 20;
      end else if (cam_vsync && cyc == vs_fall) begin
        cam_vsync = 1'b0;
      end
    end
  end

  // Monitor: every state change consumes one expected record
  initial begin
    logic [2:0] prev_st;
    ev_t e;
    prev_st = 3'd0;
    forever begin
      @(negedge clk);
      if (state != prev_st) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_transition @%0d: got state %0d->%0d, required no transition",
                   cyc, prev_st, state);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.at || state !== e.st || capture_start !== e.cs || frame_en !== e.fe ||
              busy !== e.bz || fault !== e.ft || retry_cnt !== e.rt || frame_cnt !== e.fc) begin
            fails++;
            $display("FAIL %s: got cyc=%0d st=%0d cs=%0b fe=%0b busy=%0b fault=%0b retry=%0d fcnt=%0d, required cyc=%0d st=%0d cs=%0b fe=%0b busy=%0b fault=%0b retry=%0d fcnt=%0d",
                     e.name, cyc, state, capture_start, frame_en, busy, fault, retry_cnt, frame_cnt,
                     e.at, e.st, e.cs, e.fe, e.bz, e.ft, e.rt, e.fc);
          end
        end
      end
      prev_st = state;
    end
  end

  // Stimulus: directed scenarios, expectations relative to the enable cycle t
  initial begin
    int t;
    rst_n = 1'b1;
    enable = 1'b0;
    cam_init_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("reset_values");
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(10);

    // Nominal bring-up: first raw edge lands in INIT, next two in SKIP
    t = cyc;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) vs_q.push_back(t + 120 + 200 * k);
    expect_ev("nom_pwr_wait", t + 1,    PWR_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("nom_cap_start", t + 102, INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("nom_skip",     t + 152,  SKIP,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("nom_frame_en", t + 524,  RUN,      1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    expect_ev("nom_idle_fcnt5", t + 1601, IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd5);
    wait_cyc(t + 151);  cam_init_done = 1'b1;
    wait_cyc(t + 1600); enable = 1'b0;
    wait_cyc(t + 1650); cam_init_done = 1'b0;
    wait_cyc(t + 1700);

    // Init timeout: three restarts of 16 cycles, then FAULT
    t = cyc;
    enable = 1'b1;
    expect_ev("to_pwr_wait", t + 1,    PWR_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("to_init0",    t + 102,  INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("to_restart1", t + 603,  RESTART,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd0);
    expect_ev("to_init1",    t + 619,  INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 16'd0);
    expect_ev("to_restart2", t + 1120, RESTART,  1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'd0);
    expect_ev("to_init2",    t + 1136, INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'd0);
    expect_ev("to_restart3", t + 1637, RESTART,  1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'd0);
    expect_ev("to_fault",    t + 1653, FAULT,    1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'd0);
    expect_ev("to_idle",     t + 1701, IDLE,     1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd0);
    wait_cyc(t + 1700); enable = 1'b0;
    wait_cyc(t + 1750);

    // Stall: edge coincides with watchdog expiry, then vsync stops;
    // on the retry, cam_init_done coincides with the INIT timeout
    t = cyc;
    enable = 1'b1;
    vs_q.push_back(t + 120);
    vs_q.push_back(t + 320);
    vs_q.push_back(t + 520);
    vs_q.push_back(t + 821);
    expect_ev("st_pwr_wait_clr", t + 1, PWR_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("st_init",     t + 102,  INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("st_skip",     t + 152,  SKIP,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("st_run",      t + 524,  RUN,      1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    expect_ev("st_wdog_restart", t + 1126, RESTART, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd1);
    expect_ev("st_reinit",   t + 1142, INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 16'd1);
    expect_ev("st_done_wins", t + 1643, SKIP,    1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 16'd1);
    expect_ev("st_drop_in_skip", t + 1701, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'd1);
    wait_cyc(t + 151);  cam_init_done = 1'b1;
    wait_cyc(t + 1127); cam_init_done = 1'b0;
    wait_cyc(t + 1642); cam_init_done = 1'b1;
    wait_cyc(t + 1700); enable = 1'b0;
    wait_cyc(t + 1750);

    // Re-enable clears statistics, reach RUN, then async reset
    t = cyc;
    enable = 1'b1;
    vs_q.push_back(t + 200);
    vs_q.push_back(t + 400);
    expect_ev("re_pwr_wait_clr", t + 1, PWR_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("re_init",     t + 102,  INIT,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("re_skip",     t + 103,  SKIP,     1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
    expect_ev("re_run",      t + 404,  RUN,      1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
    expect_ev("rst_idle",    t + 451,  IDLE,     1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    wait_cyc(t + 450);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_in_run");
    enable = 1'b0;
    wait_cyc(t + 460); rst_n = 1'b1;
    wait_cyc(t + 480);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_transitions: got %0d expected records left (first %s), required 0",
               exp_q.size(), exp_q[0].name);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ov5640_cap_seq.md
# ov5640_cap_seq

Bring-up and supervision sequencer for the OV5640 camera driver. Timing runs in the system `clk` domain:
- holds the driver in reset for a power-on delay, then releases it via `capture_start`;
- waits for SCCB register initialisation to finish, then discards the first frames while auto-exposure settles;
- gates downstream frame acceptance and watches vsync for stalls, restarting the driver on timeout and latching a fault after repeated failures.

## Interface
- `PWR_DLY_CYC`, 1_000_000: clk cycles from enable to `capture_start` rise (20 ms @ 50 MHz).
- `INIT_TO_CYC`, 25_000_000: max clk cycles from `capture_start` rise to `cam_init_done`.
- `SKIP_FRAMES`, 10: vsync rising edges discarded before `frame_en` asserts; 0 is legal.
- `FRAME_TO_CYC`, 5_000_000: max clk cycles between vsync rising edges while in RUN.
- `RST_HOLD_CYC`, 16: cycles `capture_start` is held low during a restart.
- `MAX_RETRY`, 3: restarts allowed per enable before FAULT; range 1..7.
- `clk` in 1: system clock, same clock as the SCCB master.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 runs the sequence, 0 returns to IDLE.
- `cam_init_done` in 1: level from the register-config engine, `clk` domain.
- `cam_vsync` in 1: raw vsync in the `cam_pclk` domain; synchronised internally.
- `capture_start` out 1: driver run/reset-release, registered.
- `frame_en` out 1: downstream may accept frame data, registered.
- `frame_cnt` out 16: frames seen in RUN, wraps at 16 bits.
- `retry_cnt` out 3: restarts since enable rose.
- `busy` out 1: 1 in PWR_WAIT, INIT, SKIP and RESTART.
- `fault` out 1: 1 in FAULT.
- `state` out 3: current state encoding, for debug.

## Operation
- Every output resets to 0, and `state` resets to IDLE.
- vsync is passed through a 2-flop synchroniser plus an edge register. `vs_rise` is a one-cycle pulse, produced 3 clk cycles after the input edge.
- One shared down-counter, `$clog2` of the largest cycle parameter wide, reloads on every state entry.

States and transitions:
- **IDLE (0)**: when `enable`=1, go to PWR_WAIT. On entry to PWR_WAIT, clear `frame_cnt` and `retry_cnt` and load `PWR_DLY_CYC`.
- **PWR_WAIT (1)**: counter reaches 0 → INIT, with `capture_start` set to 1 in the same transition.
- **INIT (2)**:
  - `cam_init_done`=1 → SKIP, or → RUN if `SKIP_FRAMES`=0.
  - Counter expires first → RESTART.
- **SKIP (3)**:
  - Count `vs_rise` pulses. The `SKIP_FRAMES`-th pulse → RUN.
  - A `FRAME_TO_CYC` watchdog runs here as well; expiry → RESTART.
- **RUN (4)**:
  - `frame_en`=1.
  - Each `vs_rise` increments `frame_cnt` and reloads the watchdog.
  - Watchdog expiry → RESTART.
- **RESTART (5)**:
  - `capture_start` and `frame_en` are 0, and `retry_cnt` increments on entry.
  - Hold for `RST_HOLD_CYC` cycles. Then, if `retry_cnt`==`MAX_RETRY` → FAULT; otherwise → INIT with `capture_start` set to 1.
- **FAULT (6)**:
  - `capture_start`=0, `frame_en`=0, `fault`=1.
  - Exit only through `enable`=0.

Global rules:
- `enable`=0 in any state → IDLE on the next edge, with `capture_start` and `frame_en` cleared.
- `frame_cnt` and `retry_cnt` keep their values in IDLE and are cleared on the next PWR_WAIT entry.
- `vs_rise` in the same cycle as a watchdog expiry: the edge wins, the watchdog reloads and there is no restart.
- `cam_init_done` and the INIT timeout expiring in the same cycle: done wins.
- A `cam_init_done` drop in SKIP or RUN is ignored; the watchdog covers loss of video.

## Timing
- Every output is registered and changes exactly 1 cycle after its transition condition.
- `capture_start` rises `PWR_DLY_CYC`+1 cycles after `enable` is sampled high.
- `frame_en` rises 1 cycle after the qualifying `vs_rise`, i.e. 4 clk cycles after the raw vsync edge. It therefore starts on a whole-frame boundary.
- `frame_en` falls 1 cycle after watchdog expiry or `enable`=0.
- The `frame_cnt` increment is visible 1 cycle after `vs_rise`.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronously), and the synchroniser flops clear.

## Structure
- Package `ov5640_ctrl_pkg` holds:
  - the state encoding constants IDLE..FAULT (3-bit, values as listed above);
  - a function computing the shared counter width from the parameters.
- Sub-module `sync_edge_det`: a 2-flop synchroniser with a rising-edge pulse output, single clock, async active-low reset.
- The FSM, shared counter, skip counter and statistics counters stay in `ov5640_cap_seq`.

## Test plan
All scenarios use `PWR_DLY_CYC`=100, `INIT_TO_CYC`=500, `SKIP_FRAMES`=2, `FRAME_TO_CYC`=300, `RST_HOLD_CYC`=16, `MAX_RETRY`=3.
- **Nominal bring-up**: enable=1; `cam_init_done` rises 50 cycles after `capture_start`; vsync period 200.
  - `capture_start` rises at cycle 101.
  - The first two edges are skipped.
  - `frame_en` rises 4 cycles after the 3rd raw vsync edge.
  - `frame_cnt`=5 after 5 more edges.
- **Init timeout**: `cam_init_done` is never asserted.
  - Three RESTART cycles occur, with `capture_start` low for 16 cycles each.
  - `retry_cnt`=3, then `fault`=1 and `busy`=0.
- **Video stall**: reach RUN, then stop vsync.
  - `frame_en` falls 301 cycles after the last `vs_rise`.
  - `retry_cnt`=1, and the sequencer returns to INIT.
- **Simultaneous events**:
  - `vs_rise` coincides with watchdog expiry → stays in RUN, `frame_cnt` increments.
  - `cam_init_done` coincides with the INIT timeout → enters SKIP.
- **Enable drop and async reset**:
  - `enable`=0 mid-SKIP → IDLE next cycle, all control outputs 0.
  - Re-enable → `frame_cnt`=0, `retry_cnt`=0.
  - `rst_n` pulsed low in RUN → all outputs 0 with no clock edge.
